sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: two-flop synchronizer plus a per-channel IDLE/COUNT stability FSM.
// Define SW_DEBOUNCE_EDGE_EN to add per-channel sw_rise/sw_fall pulse outputs.
module sw_debounce #(
  parameter int WIDTH      = 9,
  parameter int CNT_W      = 20,
  parameter int STABLE_CYC = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             sw_chg
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYC - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_sw_o;
  logic             r_chg;
  state_t           r_state     [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CNT_W-1:0] r_cnt       [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];
  logic [WIDTH-1:0] w_upd;

  // NOTE: every combinational output gets a default before the case, otherwise
  // a path that skips an assignment infers a latch.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (r_s2[i] != r_sw_o[i]) begin
            if (STABLE_CYC == 1) begin
              w_upd[i] = 1'b1;
            end else begin
              w_state_nxt[i] = ST_COUNT;
              w_cnt_nxt[i]   = CNT_W'(1);
            end
          end
        end
        ST_COUNT: begin
          if (r_s2[i] == r_sw_o[i]) begin
            // Glitch: level went back before it was stable long enough.
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == LAST_CNT) begin
            w_upd[i]       = 1'b1;
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_sw_o <= '0;
      r_chg  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_s1   <= sw_i;
      r_s2   <= r_s1;
      r_sw_o <= (r_sw_o & ~w_upd) | (r_s2 & w_upd);
      r_chg  <= |w_upd;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  assign sw_o   = r_sw_o;
  assign sw_chg = r_chg;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // An updating channel always takes the synchronized level, so its direction is r_s2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_upd & r_s2;
      r_fall <= w_upd & ~r_s2;
    end
  end

  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
`endif

endmodule
